mux8_rr_arbiter: RTL
====================

Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for the 8:1 16-bit datapath mux. It shares one 16-bit result bus among 8 requesters.
- Picks an owner, drives the mux select, and streams up to MAX_BURST words from the owner into a registered output stage with a valid/ready handshake.
- Sits between the requesting units and the shared bus consumer.

Parameters:
- WIDTH, 16, data width of each requester input and of dout.
- MAX_BURST, 4, maximum words per grant; legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  req[i]=1: requester i has a valid word on din slice i.
- din  input  8*WIDTH  requester data, flattened; slice i is din[i*WIDTH +: WIDTH].
- out_ready  input  1  consumer accepts dout this cycle.
- gnt  output  8  one-hot; gnt[i]=1 exactly in the cycles where din slice i is captured. The requester advances its data on gnt.
- sel  output  3  registered owner index, drives the mux select.
- busy  output  1  state==GRANT.
- dout  output  WIDTH  registered bus word.
- dout_valid  output  1  dout holds an unconsumed word.

Behaviour:
- Reset (async, immediate): state=IDLE, ptr=0, owner=0, sel=0, cnt=0, dout=0, dout_valid=0, gnt=0, busy=0. Reset mid-burst discards the pending dout word.
- States: IDLE, GRANT.
- IDLE, gnt=0:
  - If |req, the winner is the first set bit scanning ptr, ptr+1, ... mod 8.
  - Next cycle: state=GRANT, owner=sel=winner, cnt=0.
  - If req==0, stay in IDLE.
- GRANT:
  - load = req[owner] && (!dout_valid || out_ready).
  - gnt = onehot(owner) when load, else 0 (combinational from registered state).
  - On load: dout <= din[owner], dout_valid <= 1, cnt <= cnt+1.
  - Exit to IDLE with ptr <= owner+1 (mod 8, 7 wraps to 0) when either:
    - load && cnt==MAX_BURST-1, or
    - req[owner]==0. A dropped request ends the burst with no load that cycle.
  - Stalled (!load with req[owner]=1): hold state, cnt, sel and dout.
- Output stage:
  - dout_valid clears when dout_valid && out_ready && !load.
  - Simultaneous consume and load keeps dout_valid=1 with the new word.
  - dout and dout_valid drain independently of state, including while in IDLE.
- Latency: req asserted in IDLE -> first gnt one cycle later -> dout_valid the cycle after that.
- Throughput: one word per cycle within a burst when out_ready=1. One idle arbitration cycle between bursts.
- Fairness: a requester holding req continuously is granted within 7 bursts.
- sel changes only on the IDLE->GRANT transition, so the mux select is stable during a burst.

Decomposition:
- Shared package/include: N_REQ=8, SEL_W=3, state encodings IDLE=1'b0 and GRANT=1'b1.
- One sub-module: rr_pick8 (combinational; inputs req[7:0] and ptr[2:0]; outputs winner[2:0] and any).
- The data path instantiates the existing Mux8to1_16bits with Control=sel. The mux output feeds the dout register.

Test Plan:
- Single requester, back-to-back bursts:
  - Stimulus: MAX_BURST=4, req=8'h01, din0=16'hFFFF, out_ready=1.
  - Required: IDLE 1 cycle; gnt=8'h01 for 4 cycles; dout=16'hFFFF valid 4 cycles; 1 idle cycle with ptr=1; next burst again owner 0.
- Round-robin wrap:
  - Stimulus: req=8'h81, din0=16'hFFFF, din7=16'd10.
  - Required: owner 0 for 4 words, then owner 7 for 4 words (sel=7, dout=16'd10), then ptr wraps to 0 and owner 0 again.
- Backpressure:
  - Stimulus: owner 1 with din1=16'd11; out_ready=0 after the first word for 3 cycles.
  - Required: gnt=0, dout=16'd11 and dout_valid=1 held, cnt frozen at 1; after out_ready=1, 3 more words, total 4.
- Early drop:
  - Stimulus: owner 3 (din3=16'd15155), req[3] cleared after 2 loads, req[4]=1.
  - Required: GRANT exits with no load that cycle; ptr=4; next burst owner 4, sel=4.
- Reset mid-burst:
  - Stimulus: rst pulsed while dout_valid=1 and cnt=2.
  - Required: the same cycle, dout_valid=0, dout=0, gnt=0, sel=0; after release, arbitration restarts from ptr=0.
- Priority from ptr:
  - Stimulus: ptr=5, req=8'h24 (requesters 2 and 5).
  - Required: owner 5 first, then owner 2.

Source files
------------

// File: rtl/mux8_rr_arbiter_pkg.sv
// mux8_rr_arbiter_pkg: shared sizes and state encoding for the round-robin bus arbiter
package mux8_rr_arbiter_pkg;
  localparam int N_REQ = 8;
  localparam int SEL_W = 3;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
endpackage

// File: rtl/Mux8to1_16bits.sv
// Mux8to1_16bits: 8:1 datapath mux over a flattened input bus
module Mux8to1_16bits #(
  parameter int WIDTH = 16
) (
  input  logic [2:0]         Control,
  input  logic [8*WIDTH-1:0] data,
  output logic [WIDTH-1:0]   out
);
  always_comb out = data[Control*WIDTH +: WIDTH];
endmodule

// File: rtl/mux8_rr_arbiter_pick.sv
// rr_pick8: first set request scanning upward from ptr, wrapping mod 8
module rr_pick8
  import mux8_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] winner,
  output logic             any
);
  logic [SEL_W-1:0] idx;
  always_comb begin
    winner = ptr;
    idx = ptr;
    any = |req;
    // scan farthest first so the closest set bit to ptr is written last
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ptr + SEL_W'(k);
      if (req[idx]) winner = idx;
    end
  end
endmodule

// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: round-robin owner selection and burst streaming into a registered output stage
module mux8_rr_arbiter
  import mux8_rr_arbiter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] din,
  input  logic                   out_ready,
  output logic [N_REQ-1:0]       gnt,
  output logic [SEL_W-1:0]       sel,
  output logic                   busy,
  output logic [WIDTH-1:0]       dout,
  output logic                   dout_valid
);
  state_t state, state_next;
  logic [SEL_W-1:0] ptr, winner;
  logic [7:0] cnt;
  logic any, load, last, drop;
  logic [WIDTH-1:0] mux_out;
  rr_pick8 u_pick (.req(req), .ptr(ptr), .winner(winner), .any(any));
  Mux8to1_16bits #(.WIDTH(WIDTH)) u_mux (.Control(sel), .data(din), .out(mux_out));
  assign busy = state == GRANT;
  assign load = busy && req[sel] && (!dout_valid || out_ready);
  assign last = cnt == 8'(MAX_BURST - 1);
  assign drop = busy && !req[sel];
  assign gnt  = load ? N_REQ'(1) << sel : '0;
  always_comb begin
    state_next = state;
    state_next = !busy ? (any ? GRANT : IDLE) : ((drop || (load && last)) ? IDLE : GRANT);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      sel <= '0;
      cnt <= '0;
      dout <= '0;
      dout_valid <= 1'b0;
    end else begin
      state <= state_next;
      if (!busy && any) begin
        sel <= winner;
        cnt <= '0;
      end
      if (busy && state_next == IDLE) ptr <= sel + SEL_W'(1);
      if (load) begin
        cnt <= cnt + 8'd1;
        dout <= mux_out;
        dout_valid <= 1'b1;
      end else if (out_ready) dout_valid <= 1'b0;
    end
  end
endmodule
